// File: rtl/freq_classifier.sv
// IR beacon classifier: counts synchronized rising edges per gate window on the
// front and side detectors and publishes a confirmed none/friendly/criminal code.
module freq_classifier #(
    parameter int GATE_CYCLES = 1_000_000,
    parameter int FRIEND_MIN  = 15,
    parameter int FRIEND_MAX  = 25,
    parameter int CRIM_MIN    = 5,
    parameter int CRIM_MAX    = 8,
    parameter int CONFIRM     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ir_front,
    input  logic       ir_side,
    output logic [1:0] Ffreq,
    output logic [1:0] Sfreq,
    output logic       win_done
);
    localparam int               WIN_W     = $clog2(GATE_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
    localparam logic [15:0]      CRIM_LO   = 16'(CRIM_MIN);
    localparam logic [15:0]      CRIM_HI   = 16'(CRIM_MAX);
    localparam logic [15:0]      FRIEND_LO = 16'(FRIEND_MIN);
    localparam logic [15:0]      FRIEND_HI = 16'(FRIEND_MAX);
    localparam logic [3:0]       CONF_N    = 4'(CONFIRM);
    localparam logic [15:0]      CNT_MAX   = 16'hFFFF;

    localparam logic [1:0] CODE_NONE   = 2'd0;
    localparam logic [1:0] CODE_FRIEND = 2'd1;
    localparam logic [1:0] CODE_CRIM   = 2'd2;

    // Channel 0 is the front detector, channel 1 the side detector.
    logic [1:0]       w_irIn;
    logic [1:0][2:0]  r_sync;
    logic [1:0]       w_edge;
    logic [WIN_W-1:0] r_winCnt;
    logic             w_terminal;
    logic             r_confirmStage;
    logic [1:0][15:0] r_cnt;
    logic [1:0][15:0] w_total;
    logic [1:0][1:0]  w_clsNext;
    logic [1:0][1:0]  r_cls;
    logic [1:0][1:0]  r_cand;
    logic [1:0][1:0]  w_candNext;
    logic [1:0][3:0]  r_match;
    logic [1:0][3:0]  w_matchNext;
    logic [1:0]       w_confirmed;

    assign w_irIn     = {ir_side, ir_front};
    assign w_terminal = (r_winCnt == WIN_LAST);

    always_comb begin
        w_edge      = '0;
        w_total     = '0;
        w_clsNext   = '0;
        w_candNext  = '0;
        w_matchNext = '0;
        w_confirmed = '0;
        for (int c = 0; c < 2; c++) begin
            w_edge[c] = r_sync[c][1] & ~r_sync[c][2];
            // An edge arriving in the terminal cycle still belongs to the closing window.
            w_total[c] = (r_cnt[c] == CNT_MAX) ? CNT_MAX : r_cnt[c] + 16'(w_edge[c]);

            if (w_total[c] >= CRIM_LO && w_total[c] <= CRIM_HI)
                w_clsNext[c] = CODE_CRIM;
            else if (w_total[c] >= FRIEND_LO && w_total[c] <= FRIEND_HI)
                w_clsNext[c] = CODE_FRIEND;
            else
                w_clsNext[c] = CODE_NONE;

            w_candNext[c] = r_cls[c];
            if (r_cls[c] == r_cand[c])
                w_matchNext[c] = (r_match[c] >= CONF_N) ? CONF_N : r_match[c] + 4'd1;
            else
                w_matchNext[c] = 4'd1;
            w_confirmed[c] = (w_matchNext[c] == CONF_N);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync         <= '0;
            r_winCnt       <= '0;
            r_cnt          <= '0;
            r_cls          <= '0;
            r_confirmStage <= 1'b0;
        end else begin
            r_winCnt       <= w_terminal ? '0 : r_winCnt + WIN_W'(1);
            r_confirmStage <= w_terminal;
            for (int c = 0; c < 2; c++) begin
                r_sync[c] <= {r_sync[c][1:0], w_irIn[c]};
                if (w_terminal) begin
                    r_cnt[c] <= '0;
                    r_cls[c] <= w_clsNext[c];
                end else if (w_edge[c] && r_cnt[c] != CNT_MAX) begin
                    r_cnt[c] <= r_cnt[c] + 16'd1;
                end
            end
        end
    end

    // Confirm stage runs one cycle after the terminal cycle; win_done marks the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cand   <= '0;
            r_match  <= '0;
            Ffreq    <= CODE_NONE;
            Sfreq    <= CODE_NONE;
            win_done <= 1'b0;
        end else begin
            win_done <= r_confirmStage;
            if (r_confirmStage) begin
                r_cand  <= w_candNext;
                r_match <= w_matchNext;
                if (w_confirmed[0])
                    Ffreq <= w_candNext[0];
                if (w_confirmed[1])
                    Sfreq <= w_candNext[1];
            end
        end
    end
endmodule

// File: tb/tb_freq_classifier.sv
// Scoreboard bench for freq_classifier: random edge placements per window are
// classified by a window-level model and compared at every win_done.
module tb_freq_classifier;
    localparam int G     = 1000;
    localparam int F_MIN = 40;
    localparam int F_MAX = 60;
    localparam int C_MIN = 8;
    localparam int C_MAX = 12;
    localparam int CONF  = 2;
    localparam int SLOTS = 248;

    typedef struct {
        int         cyc;
        logic [1:0] f;
        logic [1:0] s;
    } expect_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       irFront;
    logic       irSide;
    logic [1:0] ffreq;
    logic [1:0] sfreq;
    logic       winDone;

    expect_t expQ[$];
    int      fPlan[$];
    int      sPlan[$];
    bit      forceTerm;
    bit      fLvl[];
    bit      sLvl[];
    int      fc[];
    int      sc[];
    int      cyc = -1;
    int      checks = 0;
    int      failures = 0;

    freq_classifier #(
        .GATE_CYCLES(G),
        .FRIEND_MIN (F_MIN),
        .FRIEND_MAX (F_MAX),
        .CRIM_MIN   (C_MIN),
        .CRIM_MAX   (C_MAX),
        .CONFIRM    (CONF)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ir_front(irFront),
        .ir_side (irSide),
        .Ffreq   (ffreq),
        .Sfreq   (sfreq),
        .win_done(winDone)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [1:0] classify(input int n);
        if (n >= C_MIN && n <= C_MAX) return 2'd2;
        if (n >= F_MIN && n <= F_MAX) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] clsOf(input int ch, input int k);
        return classify(ch == 0 ? fc[k] : sc[k]);
    endfunction

    // A code is adopted once the last CONF windows all classified the same way.
    function automatic bit settled(input int ch, input int k);
        if (k + 1 < CONF) return 1'b0;
        for (int i = k - CONF + 1; i <= k; i++)
            if (clsOf(ch, i) != clsOf(ch, k)) return 1'b0;
        return 1'b1;
    endfunction

    // Raise the input so that the synchronized edge lands in cycle p.
    task automatic setPulse(input int ch, input int p, input int nCyc);
        for (int t = p - 2; t < p; t++) begin
            if (t >= 0 && t < nCyc) begin
                if (ch == 0) fLvl[t] = 1'b1;
                else         sLvl[t] = 1'b1;
            end
        end
    endtask

    task automatic placeEdges(input int ch, input int k, input int n, input bit term, input int nCyc);
        int slot[SLOTS];
        int j;
        int tmp;
        int m;
        m = n;
        if (term && n > 0) begin
            setPulse(ch, k * G + G - 1, nCyc);
            m = n - 1;
        end
        for (int i = 0; i < SLOTS; i++) slot[i] = i;
        for (int i = 0; i < m; i++) begin
            j       = $urandom_range(SLOTS - 1, i);
            tmp     = slot[i];
            slot[i] = slot[j];
            slot[j] = tmp;
            setPulse(ch, k * G + 4 + 4 * slot[i], nCyc);
        end
    endtask

    task automatic buildExpected(input int nCyc);
        int         nWin;
        logic [1:0] outF;
        logic [1:0] outS;
        expect_t    e;
        nWin = nCyc / G + 1;
        fc   = new[nWin];
        sc   = new[nWin];
        for (int t = 0; t < nCyc - 2; t++) begin
            if (fLvl[t] && (t == 0 ? 1'b1 : !fLvl[t-1])) fc[(t + 2) / G]++;
            if (sLvl[t] && (t == 0 ? 1'b1 : !sLvl[t-1])) sc[(t + 2) / G]++;
        end
        outF = 2'd0;
        outS = 2'd0;
        for (int k = 0; k * G + G + 1 < nCyc; k++) begin
            if (settled(0, k)) outF = clsOf(0, k);
            if (settled(1, k)) outS = clsOf(1, k);
            e.cyc = k * G + G + 1;
            e.f   = outF;
            e.s   = outS;
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int nCyc, input int resetLen);
        checkOutput("queue drained", expQ.size(), 0);
        fLvl = new[nCyc];
        sLvl = new[nCyc];
        foreach (fPlan[k]) placeEdges(0, k, fPlan[k], forceTerm || ($urandom_range(3, 0) == 0), nCyc);
        foreach (sPlan[k]) placeEdges(1, k, sPlan[k], forceTerm || ($urandom_range(3, 0) == 0), nCyc);
        buildExpected(nCyc);
        cyc     = -1;
        reset   = 1'b1;
        irFront = 1'b0;
        irSide  = 1'b0;
        repeat (resetLen) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int t = 0; t < nCyc; t++) begin
            cyc     = t;
            irFront = fLvl[t];
            irSide  = sLvl[t];
            @(posedge clock);
            #1;
        end
    endtask

    task automatic setPlans(input int nWin, input int fVal, input int sVal);
        fPlan.delete();
        sPlan.delete();
        for (int k = 0; k < nWin; k++) begin
            fPlan.push_back(fVal);
            sPlan.push_back(sVal);
        end
    endtask

    initial begin : monitor
        bit         rstAtEdge;
        logic [1:0] expF;
        logic [1:0] expS;
        expect_t    e;
        expF = 2'd0;
        expS = 2'd0;
        forever begin
            @(posedge clock);
            rstAtEdge = reset;
            @(negedge clock);
            if (rstAtEdge) begin
                expF = 2'd0;
                expS = 2'd0;
                checkOutput("reset Ffreq", ffreq, 0);
                checkOutput("reset Sfreq", sfreq, 0);
                checkOutput("reset win_done", winDone, 0);
            end else begin
                if (winDone) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected win_done", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("win_done cycle", cyc, e.cyc);
                        expF = e.f;
                        expS = e.s;
                    end
                end else if (expQ.size() > 0 && cyc > expQ[0].cyc) begin
                    e = expQ.pop_front();
                    checkOutput("missing win_done", 0, 1);
                    expF = e.f;
                    expS = e.s;
                end
                checkOutput("Ffreq", ffreq, expF);
                checkOutput("Sfreq", sfreq, expS);
            end
        end
    end

    initial begin : stimulus
        int pool[13];
        int seq4[8];
        int seq5[14];
        pool = '{0, 5, 8, 10, 12, 13, 20, 39, 40, 50, 60, 61, 100};
        seq4 = '{50, 10, 50, 10, 50, 10, 10, 10};
        seq5 = '{8, 8, 12, 12, 13, 13, 39, 39, 40, 40, 60, 60, 61, 61};
        reset     = 1'b1;
        irFront   = 1'b0;
        irSide    = 1'b0;
        forceTerm = 1'b0;

        $display("[TB] quiet inputs");
        setPlans(0, 0, 0);
        applyStimulus(5 * G + 10, 5);

        $display("[TB] friendly front");
        setPlans(4, 50, 0);
        applyStimulus(4 * G + 10, 5);

        $display("[TB] friendly front, criminal side");
        setPlans(4, 50, 10);
        applyStimulus(4 * G + 10, 5);

        $display("[TB] alternating front");
        setPlans(0, 0, 0);
        foreach (seq4[k]) begin
            fPlan.push_back(seq4[k]);
            sPlan.push_back($urandom_range(70, 0));
        end
        applyStimulus(8 * G + 10, 5);

        $display("[TB] boundary counts with terminal-cycle edges");
        setPlans(0, 0, 0);
        foreach (seq5[k]) begin
            fPlan.push_back(seq5[k]);
            sPlan.push_front(seq5[k]);
        end
        forceTerm = 1'b1;
        applyStimulus(14 * G + 10, 5);
        forceTerm = 1'b0;

        $display("[TB] mid-window reset");
        setPlans(4, 50, 0);
        applyStimulus(3 * G + 500, 5);
        setPlans(3, 50, 0);
        applyStimulus(3 * G + 10, 1);

        $display("[TB] random windows");
        setPlans(0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            fPlan.push_back(pool[$urandom_range(12, 0)]);
            sPlan.push_back(pool[$urandom_range(12, 0)]);
        end
        applyStimulus(10 * G + 10, 5);

        checkOutput("queue drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
